// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_sched systolic-array scheduler.
// Direction encodings match the PE_mode bits broadcast to every PE_MAC.
package rsa_pkg;

  // PE_mode[0]: horizontal flow direction
  typedef enum logic {W_2_E = 1'b0, E_2_W = 1'b1} h_dir_e;
  // PE_mode[1]: vertical flow direction
  typedef enum logic {N_2_S = 1'b0, S_2_N = 1'b1} v_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int SETTLE_CYC = 2;
  localparam int SETTLE_W   = 2;

  function automatic int res_cnt_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/rsa_skew_gen.sv
// One edge lane: after i_start, raises o_en for i_k cycles beginning i_skew
// cycles later, then o_done for exactly one cycle. Both outputs are flops.
module rsa_skew_gen #(
  parameter int K_W   = 8,
  parameter int CNT_W = K_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [K_W-1:0]   i_k,
  input  logic [CNT_W-1:0] i_skew,
  output logic             o_en,
  output logic             o_done
);

  logic             r_run;
  logic [CNT_W-1:0] r_idx;
  logic             r_en;
  logic             r_done;

  logic             w_run_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_end;

  assign w_end = i_skew + CNT_W'(i_k);

  // Outputs are decoded from the next lane index so they land registered
  // exactly in the cycle that index names.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_run_nxt = r_run;
    w_idx_nxt = r_idx;
    if (i_start) begin
      w_run_nxt = 1'b1;
      w_idx_nxt = '0;
    end else if (r_run) begin
      if (r_idx >= w_end) w_run_nxt = 1'b0;
      else                w_idx_nxt = r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_idx  <= '0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_run  <= w_run_nxt;
      r_idx  <= w_idx_nxt;
      r_en   <= w_run_nxt && (w_idx_nxt >= i_skew) && (w_idx_nxt < w_end);
      r_done <= w_run_nxt && (w_idx_nxt == w_end);
    end
  end

  assign o_en   = r_en;
  assign o_done = r_done;

endmodule

// File: rtl/rsa_sched.sv
// Command scheduler for the ROWS x COLS PE_MAC array: fixes PE_mode, issues
// skewed edge enables, then counts result beats until complete or timed out.
module rsa_sched
  import rsa_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_W       = 8,
  parameter int DRAIN_MAX = 64
) (
  input  logic                               clk,
  input  logic                               sys_rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_mode,
  input  logic [K_W-1:0]                     cmd_k,
  output logic [1:0]                         PE_mode,
  output logic [COLS-1:0]                    cal_en_col,
  output logic [COLS-1:0]                    cal_done_col,
  output logic [ROWS-1:0]                    a_rd_en,
  output logic [COLS-1:0]                    b_rd_en,
  output logic                               buf_rewind,
  input  logic [ROWS-1:0]                    res_val_row,
  output logic [res_cnt_w(ROWS, COLS)-1:0]   res_cnt,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int NRES  = ROWS * COLS;
  localparam int RC_W  = res_cnt_w(ROWS, COLS);
  localparam int CNT_W = K_W + 1;
  localparam int DC_W  = $clog2(DRAIN_MAX + 1);
  localparam int LANES = ROWS + COLS;

  state_t              r_state, w_state_nxt;
  logic [K_W-1:0]      r_k;
  logic [1:0]          r_pe_mode;
  logic                r_buf_rewind;
  logic                r_err;
  logic [RC_W-1:0]     r_res_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [DC_W-1:0]     r_drain_cnt;
  logic [LANES-1:0]    r_lane_seen;

  logic                w_accept;
  logic                w_start;
  logic                w_counting;
  logic                w_res_full;
  logic                w_drain_to;
  logic                w_feed_end;
  logic [ROWS-1:0]     w_row_done;
  logic [LANES-1:0]    w_lane_done;
  logic [RC_W:0]       w_pop;
  logic [RC_W:0]       w_res_sum;
  logic [RC_W-1:0]     w_res_nxt;

  assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
  assign w_start     = (r_state == ST_SETTLE) &&
                       (r_settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
  assign w_counting  = (r_state == ST_FEED) || (r_state == ST_DRAIN);
  assign w_res_full  = (r_res_cnt == RC_W'(NRES));
  assign w_drain_to  = (r_drain_cnt == DC_W'(DRAIN_MAX - 1));
  assign w_lane_done = {w_row_done, cal_done_col};
  // FEED ends in the cycle the last lane shows its done pulse.
  assign w_feed_end  = &(r_lane_seen | w_lane_done);

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [CNT_W-1:0] w_skew;
    assign w_skew = (h_dir_e'(r_pe_mode[0]) == W_2_E) ? CNT_W'(j) : CNT_W'(COLS - 1 - j);
    rsa_skew_gen #(.K_W(K_W), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (sys_rst_n),
      .i_start(w_start),
      .i_k    (r_k),
      .i_skew (w_skew),
      .o_en   (cal_en_col[j]),
      .o_done (cal_done_col[j])
    );
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic [CNT_W-1:0] w_skew;
    assign w_skew = (v_dir_e'(r_pe_mode[1]) == N_2_S) ? CNT_W'(i) : CNT_W'(ROWS - 1 - i);
    rsa_skew_gen #(.K_W(K_W), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (sys_rst_n),
      .i_start(w_start),
      .i_k    (r_k),
      .i_skew (w_skew),
      .o_en   (a_rd_en[i]),
      .o_done (w_row_done[i])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < ROWS; i++) w_pop = w_pop + (RC_W + 1)'(res_val_row[i]);
    w_res_sum = {1'b0, r_res_cnt} + w_pop;
    w_res_nxt = (w_res_sum > (RC_W + 1)'(NRES)) ? RC_W'(NRES) : w_res_sum[RC_W-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = (cmd_k == '0) ? ST_DONE : ST_SETTLE;
      ST_SETTLE: if (w_start) w_state_nxt = ST_FEED;
      ST_FEED:   if (w_feed_end) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_res_full || w_drain_to) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_pe_mode    <= '0;
      r_buf_rewind <= 1'b0;
      r_err        <= 1'b0;
      r_res_cnt    <= '0;
      r_settle_cnt <= '0;
      r_drain_cnt  <= '0;
      r_lane_seen  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf_rewind <= w_accept;
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      r_drain_cnt  <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_k         <= cmd_k;
        r_pe_mode   <= cmd_mode;
        r_err       <= (cmd_k == '0);
        r_res_cnt   <= '0;
        r_lane_seen <= '0;
      end else begin
        if (w_counting) r_res_cnt <= w_res_nxt;
        if (r_state == ST_FEED) r_lane_seen <= r_lane_seen | w_lane_done;
        if ((r_state == ST_DRAIN) && !w_res_full && w_drain_to) r_err <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign err        = r_err;
  assign PE_mode    = r_pe_mode;
  assign buf_rewind = r_buf_rewind;
  assign res_cnt    = r_res_cnt;
  assign b_rd_en    = cal_en_col;

endmodule

// File: tb/tb_rsa_sched.sv
// Self-checking bench for rsa_sched: each command is predicted cycle by cycle
// from window arithmetic and a saturating beat count, with random result beats.
module tb_rsa_sched;
  import rsa_pkg::*;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int K_W       = 8;
  localparam int DRAIN_MAX = 64;
  localparam int NRES      = ROWS * COLS;
  localparam int M         = (ROWS > COLS) ? ROWS : COLS;
  localparam int RC_W      = res_cnt_w(ROWS, COLS);

  logic            clk = 1'b0;
  logic            sys_rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_mode;
  logic [K_W-1:0]  cmd_k;
  logic [1:0]      PE_mode;
  logic [COLS-1:0] cal_en_col;
  logic [COLS-1:0] cal_done_col;
  logic [ROWS-1:0] a_rd_en;
  logic [COLS-1:0] b_rd_en;
  logic            buf_rewind;
  logic [ROWS-1:0] res_val_row;
  logic [RC_W-1:0] res_cnt;
  logic            busy;
  logic            done;
  logic            err;

  rsa_sched #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_k       (cmd_k),
    .PE_mode     (PE_mode),
    .cal_en_col  (cal_en_col),
    .cal_done_col(cal_done_col),
    .a_rd_en     (a_rd_en),
    .b_rd_en     (b_rd_en),
    .buf_rewind  (buf_rewind),
    .res_val_row (res_val_row),
    .res_cnt     (res_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [1:0] exp_mode;
  logic       exp_err;
  int         exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [COLS-1:0] e_cal, input logic [COLS-1:0] e_cdone,
                               input logic [ROWS-1:0] e_a, input logic e_rew,
                               input logic e_done, input logic e_busy);
    check("cal_en_col",   32'(cal_en_col),   32'(e_cal));
    check("b_rd_en",      32'(b_rd_en),      32'(e_cal));
    check("cal_done_col", 32'(cal_done_col), 32'(e_cdone));
    check("a_rd_en",      32'(a_rd_en),      32'(e_a));
    check("buf_rewind",   32'(buf_rewind),   32'(e_rew));
    check("done",         32'(done),         32'(e_done));
    check("busy",         32'(busy),         32'(e_busy));
    check("cmd_ready",    32'(cmd_ready),    32'(!e_busy));
    check("err",          32'(err),          32'(exp_err));
    check("PE_mode",      32'(PE_mode),      32'(exp_mode));
    check("res_cnt",      32'(res_cnt),      32'(exp_cnt));
  endtask

  // Idle cycles: no command offered, result beats are noise and must be ignored.
  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cmd_valid   = 1'b0;
      cmd_mode    = 2'($urandom);
      cmd_k       = K_W'($urandom);
      res_val_row = ROWS'($urandom);
      @(negedge clk);
      check_outputs('0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one command in the current (idle) cycle and follow it to its done
  // cycle. budget = number of result beats the fake array returns in total.
  task automatic run_cmd(input logic [1:0] mode, input int k, input int budget,
                         input bit hold, input logic [1:0] nmode, input int nk,
                         input int stop_r);
    int r, s, sj, ri, delivered, done_r, d_start;
    logic [COLS-1:0] ec, ed;
    logic [ROWS-1:0] ea, rv;
    bit feed, drain;
    done_r    = (k == 0) ? 1 : -1;
    d_start   = 3 + k + M;
    delivered = 0;
    for (r = 0; r <= 400; r++) begin
      if (r == 0) begin
        cmd_valid = 1'b1; cmd_mode = mode; cmd_k = K_W'(k);
      end else if (hold) begin
        cmd_valid = 1'b1; cmd_mode = nmode; cmd_k = K_W'(nk);
      end else begin
        cmd_valid = 1'($urandom); cmd_mode = 2'($urandom); cmd_k = K_W'($urandom);
      end
      feed  = (k > 0) && (r >= 3) && (r < d_start);
      drain = (k > 0) && (r >= d_start) && (done_r < 0);
      rv = ROWS'($urandom);
      if (feed || drain)
        while ($countones(rv) > budget - delivered) rv = rv & (rv - 1'b1);
      res_val_row = rv;
      ec = '0; ed = '0; ea = '0;
      if (feed) begin
        s = r - 3;
        for (int j = 0; j < COLS; j++) begin
          sj = mode[0] ? COLS - 1 - j : j;
          ec[j] = (s >= sj) && (s < sj + k);
          ed[j] = (s == sj + k);
        end
        for (int i = 0; i < ROWS; i++) begin
          ri = mode[1] ? ROWS - 1 - i : i;
          ea[i] = (s >= ri) && (s < ri + k);
        end
      end
      @(negedge clk);
      check_outputs(ec, ed, ea, r == 1, r == done_r, r != 0);
      if (r == 0) begin
        exp_mode = mode; exp_err = (k == 0); exp_cnt = 0;
      end
      if (drain) begin
        if (exp_cnt == NRES) done_r = r + 1;
        else if (r - d_start == DRAIN_MAX - 1) begin done_r = r + 1; exp_err = 1'b1; end
      end
      if (feed || drain) begin
        delivered += $countones(rv);
        exp_cnt = (exp_cnt + $countones(rv) > NRES) ? NRES : exp_cnt + $countones(rv);
      end
      @(posedge clk);
      #1;
      if (r == done_r || r == stop_r) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_k = '0; res_val_row = '0;
    exp_mode = '0; exp_err = 1'b0; exp_cnt = 0;
    #3;
    check_outputs('0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 sys_rst_n = 1'b1;
    idle_cycles(2);

    // Directed windows, normal and mirrored modes.
    run_cmd(2'b00, 3, 16, 1'b0, 2'b00, 0, -1);
    idle_cycles(2);
    run_cmd(2'b11, 2, 16, 1'b0, 2'b00, 0, -1);
    // Zero-length command.
    run_cmd(2'b10, 0, 0, 1'b0, 2'b00, 0, -1);
    idle_cycles(1);
    // One beat withheld: drain timeout.
    run_cmd(2'b01, 2, 15, 1'b0, 2'b00, 0, -1);
    idle_cycles(1);
    // Command held through busy, then accepted again in idle with mode 01.
    run_cmd(2'b00, 4, 16, 1'b1, 2'b01, 3, -1);
    run_cmd(2'b01, 3, 20, 1'b0, 2'b00, 0, -1);
    idle_cycles(1);
    // Random commands, some with surplus beats to exercise saturation.
    for (int n = 0; n < 6; n++) begin
      run_cmd(2'($urandom), $urandom_range(1, 7), $urandom_range(16, 22),
              1'b0, 2'b00, 0, -1);
      idle_cycles($urandom_range(0, 2));
    end
    // Reset in the middle of FEED.
    run_cmd(2'b10, 6, 16, 1'b0, 2'b00, 0, 6);
    cmd_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    exp_mode = '0; exp_err = 1'b0; exp_cnt = 0;
    check_outputs('0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 sys_rst_n = 1'b1;
    idle_cycles(1);
    run_cmd(2'($urandom), 1, 16, 1'b0, 2'b00, 0, -1);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
